// File: rtl/risc_pkg.sv
// Shared types for the data-memory port arbiter of the pipelined RISC.
package risc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        EXT_ACC
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_EXT
    } requester_t;

    // Only word accesses exist, so anything off a 4-byte boundary is illegal.
    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/arb_wait_timer.sv
// Loadable down-counter that paces each memory access through its wait states.
module arb_wait_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and an external requester,
// sequencing every access through a fixed wait-state window.
module dmem_port_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              cpu_misalign_o,
    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic [DATA_W-1:0] ext_rdata_o,
    output logic              ext_valid_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t          state, state_nxt;
    requester_t          winner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                cpu_aligned, cpu_valid, ext_aligned;
    logic                grant_cpu, grant_ext, grant_mem;
    logic                wait_zero, acc_done, cpu_done;

    assign cpu_aligned    = word_aligned(cpu_addr_i[1:0]);
    assign ext_aligned    = word_aligned(ext_addr_i[1:0]);
    assign cpu_valid      = cpu_req_i & ~halt_i & cpu_aligned;
    assign acc_done       = (state != IDLE) && wait_zero;
    assign cpu_done       = (state == CPU_ACC) && wait_zero;
    assign grant_mem      = grant_cpu | (grant_ext & ext_aligned);

    assign cpu_stall_o    = ~rst & cpu_valid & ~cpu_done;
    assign cpu_misalign_o = cpu_req_i & ~cpu_aligned;
    assign ext_gnt_o      = grant_ext;

    arb_wait_timer #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_timer (
        .clk  (clk),
        .rst  (rst),
        .load (grant_mem),
        .dec  (state != IDLE),
        .zero (wait_zero)
    );

    // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        winner    = REQ_CPU;
        grant_cpu = 1'b0;
        grant_ext = 1'b0;
        case (state)
            IDLE: begin
                if (ext_req_i && (!cpu_valid || starve_cnt == STARVE_W'(STARVE_MAX))) begin
                    winner = REQ_EXT;
                end
                // Grants are suppressed during reset so no pulse escapes that the flops never saw.
                grant_cpu = ~rst & cpu_valid & (winner == REQ_CPU);
                grant_ext = ~rst & ext_req_i & (winner == REQ_EXT);
                if (grant_cpu) begin
                    state_nxt = CPU_ACC;
                end else if (grant_ext && ext_aligned) begin
                    state_nxt = EXT_ACC;
                end
            end
            CPU_ACC, EXT_ACC: begin
                if (wait_zero) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            cpu_rdata_o <= '0;
            ext_rdata_o <= '0;
            ext_valid_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_en_o    <= 1'b0;
            ext_valid_o <= 1'b0;

            if (grant_cpu) begin
                mem_en_o    <= 1'b1;
                mem_we_o    <= cpu_we_i;
                mem_addr_o  <= cpu_addr_i;
                mem_wdata_o <= cpu_wdata_i;
                starve_cnt  <= ext_req_i ? starve_cnt + 1'b1 : '0;
            end else if (grant_ext) begin
                starve_cnt <= '0;
                if (ext_aligned) begin
                    mem_en_o    <= 1'b1;
                    mem_we_o    <= ext_we_i;
                    mem_addr_o  <= ext_addr_i;
                    mem_wdata_o <= ext_wdata_i;
                end else begin
                    // Misaligned external access is acknowledged without touching memory.
                    ext_valid_o <= 1'b1;
                end
            end

            // mem_we_o still holds the direction of the access that is completing.
            if (acc_done && !mem_we_o) begin
                if (state == CPU_ACC) begin
                    cpu_rdata_o <= mem_rdata_i;
                end else begin
                    ext_rdata_o <= mem_rdata_i;
                end
            end
            if (acc_done && state == EXT_ACC) begin
                ext_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, directed corner cases,
// and randomized single-requester traffic against a transaction-level memory model.
module tb_dmem_port_arbiter;

    localparam int WAIT_CYCLES = 2;
    localparam int STARVE_MAX  = 2;
    localparam int CPU_LAT     = WAIT_CYCLES + 1;  // stalled cycles for an unobstructed CPU access
    localparam int EXT_LAT     = WAIT_CYCLES + 2;  // cycles from ext_gnt_o to ext_valid_o
    localparam int LIMIT       = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_i = 1'b0;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o, cpu_misalign_o;
    logic        ext_req_i = 1'b0, ext_we_i = 1'b0;
    logic [31:0] ext_addr_i = '0, ext_wdata_i = '0;
    logic        ext_gnt_o, ext_valid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT_CYCLES), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst), .halt_i(halt_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .cpu_misalign_o(cpu_misalign_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
        .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rdata_o(ext_rdata_o),
        .ext_valid_o(ext_valid_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEAD_BEEF : ((32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000);
    endfunction

    // Memory environment plus access monitors, all sampled mid-cycle.
    logic [31:0] env_mem [256];
    logic        filled = 1'b0;
    int          en_cnt = 0;
    int          val_cnt = 0;
    logic [31:0] grant_q [$];

    always @(negedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
            filled = 1'b1;
        end
        if (mem_en_o) begin
            en_cnt++;
            grant_q.push_back(mem_addr_o);
            if (mem_we_o) env_mem[mem_addr_o[9:2]] = mem_wdata_o;
        end
        if (ext_valid_o) val_cnt++;
    end

    assign mem_rdata_i = env_mem[mem_addr_o[9:2]];

    // Reference memory contents, updated from the transactions the bench issues.
    logic [31:0] ref_mem [256];
    logic [31:0] exp_cpu_rd = '0;
    logic [31:0] exp_ext_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        halt_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
        ext_req_i = 1'b0; ext_we_i = 1'b0; ext_addr_i = '0; ext_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Holds a CPU request until the stall drops; n counts stalled cycles.
    task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
        n = 0;
        @(negedge clk);
        while (cpu_stall_o && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("cpu_op stall within bound", n < LIMIT, 1'b1);
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
    endtask

    // g = cycles waited for the grant, l = cycles from grant to ext_valid_o.
    task automatic ext_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int g, output int l);
        ext_req_i = 1'b1; ext_we_i = we; ext_addr_i = addr; ext_wdata_i = wdata;
        g = 0;
        @(negedge clk);
        while (!ext_gnt_o && g < LIMIT) begin
            g++;
            @(negedge clk);
        end
        check("ext_op grant within bound", g < LIMIT, 1'b1);
        @(posedge clk);
        #1 ext_req_i = 1'b0;
        l = 1;
        @(negedge clk);
        while (!ext_valid_o && l < LIMIT) begin
            l++;
            @(negedge clk);
        end
        check("ext_op valid within bound", l < LIMIT, 1'b1);
        rd = ext_rdata_o;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        halt;
        logic        cpu_req;
        logic [31:0] cpu_addr;
        logic        ext_req;
        logic [31:0] ext_addr;
        logic        exp_stall;
        logic        exp_misalign;
        logic        exp_gnt;
        logic        exp_en;     // mem_en_o in the following cycle
        logic        exp_valid;  // ext_valid_o in the following cycle
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] exp_order [4];
    logic [31:0] rd, rd_c;
    int          n, g, l, n_c, g_c, l_c, e0, v0, qs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not reach its summary line");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        //               halt req  cpu_addr     ext  ext_addr    stall mis gnt en  valid
        vecs[0] = '{1'b0, 1'b0, 32'h10, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h12, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h13, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h12, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values, with live requests that must be masked while rst is high.
        cpu_req_i = 1'b1; cpu_addr_i = 32'h10; ext_req_i = 1'b1; ext_addr_i = 32'h20;
        @(negedge clk);
        check("reset cpu_stall_o", cpu_stall_o, 1'b0);
        check("reset ext_gnt_o", ext_gnt_o, 1'b0);
        check("reset mem_en_o", mem_en_o, 1'b0);
        check("reset mem_addr_o", mem_addr_o, 32'h0);
        check("reset cpu_rdata_o", cpu_rdata_o, 32'h0);
        check("reset ext_valid_o", ext_valid_o, 1'b0);
        do_reset();

        // Single-cycle decisions from a clean IDLE state.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            halt_i = vecs[i].halt; cpu_req_i = vecs[i].cpu_req; cpu_addr_i = vecs[i].cpu_addr;
            ext_req_i = vecs[i].ext_req; ext_addr_i = vecs[i].ext_addr;
            @(negedge clk);
            check($sformatf("vec%0d cpu_stall_o", i), cpu_stall_o, vecs[i].exp_stall);
            check($sformatf("vec%0d cpu_misalign_o", i), cpu_misalign_o, vecs[i].exp_misalign);
            check($sformatf("vec%0d ext_gnt_o", i), ext_gnt_o, vecs[i].exp_gnt);
            @(posedge clk);
            #1 clear_inputs();
            @(negedge clk);
            check($sformatf("vec%0d mem_en_o", i), mem_en_o, vecs[i].exp_en);
            check($sformatf("vec%0d ext_valid_o", i), ext_valid_o, vecs[i].exp_valid);
        end

        // A: CPU load of 0x10, exact cycle timing.
        do_reset();
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("A k%0d cpu_stall_o", k), cpu_stall_o, k <= 2);
            check($sformatf("A k%0d mem_en_o", k), mem_en_o, k == 1);
            if (k == 1) check("A mem_addr_o", mem_addr_o, 32'h10);
            if (k == 3) check("A cpu_rdata_o not early", cpu_rdata_o, 32'h0);
            if (k == 4) check("A cpu_rdata_o", cpu_rdata_o, 32'hDEAD_BEEF);
            @(posedge clk);
            #1;
            if (k == 3) cpu_req_i = 1'b0;
        end

        // B: simultaneous CPU and EXT requests; CPU first, EXT afterwards.
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h20;
        ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h24;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("B k%0d ext_gnt_o", k), ext_gnt_o, k == 4);
            check($sformatf("B k%0d ext_valid_o", k), ext_valid_o, k == 8);
            if (k == 4) check("B cpu_rdata_o", cpu_rdata_o, ref_mem[8]);
            if (k == 8) check("B ext_rdata_o", ext_rdata_o, ref_mem[9]);
            @(posedge clk);
            #1;
            if (k == 3) cpu_req_i = 1'b0;
            if (k == 4) ext_req_i = 1'b0;
        end
        exp_ext_rd = ref_mem[9];

        // C: starvation limit forces the external grant between CPU stores.
        qs = grant_q.size();
        exp_order = '{32'h100, 32'h104, 32'h200, 32'h108};
        fork
            begin
                cpu_op(1'b1, 32'h100, 32'h1111_0000, n_c);
                cpu_op(1'b1, 32'h104, 32'h1111_0001, n_c);
                cpu_op(1'b1, 32'h108, 32'h1111_0002, n_c);
            end
            ext_op(1'b1, 32'h200, 32'h2222_0000, rd_c, g_c, l_c);
        join
        ref_mem[32'h100 >> 2] = 32'h1111_0000;
        ref_mem[32'h104 >> 2] = 32'h1111_0001;
        ref_mem[32'h108 >> 2] = 32'h1111_0002;
        ref_mem[32'h200 >> 2] = 32'h2222_0000;
        check("C grant count", grant_q.size() - qs, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("C grant order %0d", i), grant_q[qs + i], exp_order[i]);
        end
        check("C ext grant waited two CPU accesses", g_c, 2 * (WAIT_CYCLES + 2));
        check("C starve_cnt back to zero", dut.starve_cnt, 0);

        // D: misaligned CPU access never stalls nor reaches memory.
        e0 = en_cnt;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h12;
        repeat (3) begin
            @(negedge clk);
            check("D cpu_misalign_o", cpu_misalign_o, 1'b1);
            check("D cpu_stall_o", cpu_stall_o, 1'b0);
        end
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
        @(posedge clk);
        #1 check("D no memory access", en_cnt - e0, 0);

        // E: halted core, external write then read-back, CPU request ignored.
        e0 = en_cnt; v0 = val_cnt;
        halt_i = 1'b1;
        cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h44; cpu_wdata_i = 32'h0BAD_0BAD;
        ext_op(1'b1, 32'h40, 32'hA5A5_A5A5, rd, g, l);
        check("E write grant wait", g, 0);
        check("E write latency", l, EXT_LAT);
        ref_mem[16] = 32'hA5A5_A5A5;
        ext_op(1'b0, 32'h40, 32'h0, rd, g, l);
        check("E read latency", l, EXT_LAT);
        check("E read data", rd, 32'hA5A5_A5A5);
        exp_ext_rd = 32'hA5A5_A5A5;
        @(negedge clk);
        check("E cpu_stall_o while halted", cpu_stall_o, 1'b0);
        @(posedge clk);
        #1;
        check("E memory accesses", en_cnt - e0, 2);
        check("E valid pulses", val_cnt - v0, 2);
        clear_inputs();

        // F: reset one cycle after mem_en_o of an external read.
        ext_req_i = 1'b1; ext_we_i = 1'b0; ext_addr_i = 32'h40;
        @(negedge clk);
        check("F ext_gnt_o", ext_gnt_o, 1'b1);
        @(posedge clk);
        #1 ext_req_i = 1'b0;
        @(negedge clk);
        check("F mem_en_o", mem_en_o, 1'b1);
        @(posedge clk);
        #1;
        v0 = val_cnt;
        rst = 1'b1; cpu_req_i = 1'b1; cpu_addr_i = 32'h10;
        #1;
        check("F rst mem_en_o", mem_en_o, 1'b0);
        check("F rst mem_we_o", mem_we_o, 1'b0);
        check("F rst mem_addr_o", mem_addr_o, 32'h0);
        check("F rst mem_wdata_o", mem_wdata_o, 32'h0);
        check("F rst ext_rdata_o", ext_rdata_o, 32'h0);
        check("F rst cpu_rdata_o", cpu_rdata_o, 32'h0);
        check("F rst ext_valid_o", ext_valid_o, 1'b0);
        check("F rst ext_gnt_o", ext_gnt_o, 1'b0);
        check("F rst cpu_stall_o", cpu_stall_o, 1'b0);
        cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("F no completion after reset", val_cnt - v0, 0);
        exp_ext_rd = '0; exp_cpu_rd = '0;
        ext_op(1'b0, 32'h40, 32'h0, rd, g, l);
        check("F clean grant wait", g, 0);
        check("F clean latency", l, EXT_LAT);
        check("F clean read data", rd, ref_mem[16]);
        exp_ext_rd = ref_mem[16];

        // Randomized single-requester traffic against the reference memory.
        for (int it = 0; it < 40; it++) begin
            logic        we, hlt, mis, use_ext;
            logic [31:0] a, d;
            we = 1'($urandom_range(0, 1));
            use_ext = 1'($urandom_range(0, 1));
            hlt = ($urandom_range(0, 3) == 0);
            mis = use_ext && ($urandom_range(0, 7) == 0);
            a = 32'($urandom_range(0, 255)) << 2;
            if (mis) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            e0 = en_cnt; v0 = val_cnt;
            halt_i = hlt;
            if (use_ext) begin
                ext_op(we, a, d, rd, g, l);
                if (!mis && we) ref_mem[a[9:2]] = d;
                if (!mis && !we) exp_ext_rd = ref_mem[a[9:2]];
                check($sformatf("rnd%0d ext grant wait", it), g, 0);
                check($sformatf("rnd%0d ext latency", it), l, mis ? 1 : EXT_LAT);
                check($sformatf("rnd%0d ext rdata", it), rd, exp_ext_rd);
                check($sformatf("rnd%0d ext accesses", it), en_cnt - e0, mis ? 0 : 1);
                check($sformatf("rnd%0d ext valid pulses", it), val_cnt - v0, 1);
            end else begin
                cpu_op(we, a, d, n);
                if (!hlt && we) ref_mem[a[9:2]] = d;
                if (!hlt && !we) exp_cpu_rd = ref_mem[a[9:2]];
                check($sformatf("rnd%0d cpu stall cycles", it), n, hlt ? 0 : CPU_LAT);
                @(negedge clk);
                check($sformatf("rnd%0d cpu rdata", it), cpu_rdata_o, exp_cpu_rd);
                @(posedge clk);
                #1 check($sformatf("rnd%0d cpu accesses", it), en_cnt - e0, hlt ? 0 : 1);
            end
            halt_i = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
